// File: rtl/dq_symbol_packer.sv
// dq_symbol_packer: Gray-maps winning dq candidates to 12-bit symbols, packs
// SYM_PER_WORD symbols per word and queues words in a show-ahead FIFO behind a
// valid/ready output. Optional per-symbol erasure flags are compiled in with
// the macro DQ_PACK_ERASURE_EN.
//
// state  | meaning
// S_IDLE | no partial word held (pack_cnt == 0)
// S_FILL | partial word held, waiting for more symbols or a flush
module dq_symbol_packer #(
    parameter int N            = 32,
    parameter int SYM_PER_WORD = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [N-1:0]           in_dq_min,
    input  logic [4:0]                    in_q_min,
    input  logic signed [2:0]             in_m_dI1,
    input  logic signed [2:0]             in_m_dI2,
    input  logic signed [2:0]             in_m_dQ1,
    input  logic signed [2:0]             in_m_dQ2,
`ifdef DQ_PACK_ERASURE_EN
    input  logic signed [N-1:0]           in_thresh,
    output logic [SYM_PER_WORD-1:0]       out_erase,
`endif
    input  logic                          flush,
    output logic [12*SYM_PER_WORD-1:0]    out_data,
    output logic [2:0]                    out_count,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          sym_err,
    output logic                          overflow
);

    localparam int WORD_W = 12 * SYM_PER_WORD;
    localparam int PW     = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    // m in -4..3: Gray code by magnitude band
    function automatic logic [1:0] gray_map(input logic signed [2:0] m);
        logic [1:0] g;
        case (m)
            3'b100, 3'b101, 3'b110: g = 2'b00;
            3'b111:                 g = 2'b01;
            3'b000, 3'b001:         g = 2'b11;
            default:                g = 2'b10;
        endcase
        return g;
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_pack_cnt;
    logic [WORD_W-1:0]         r_pack_data;
    logic [11:0]               w_sym;
    logic                      w_sym_bad;
    logic [WORD_W-1:0]         w_slot_data;
    logic [2:0]                w_cnt_after;
    logic                      w_word_done;
    logic                      w_push;

    logic [WORD_W-1:0]         r_mem_data  [FIFO_DEPTH];
    logic [2:0]                r_mem_count [FIFO_DEPTH];
    logic [PW:0]               r_wr_ptr;
    logic [PW:0]               r_rd_ptr;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_wr_en;
    logic                      w_drop;

`ifdef DQ_PACK_ERASURE_EN
    logic [SYM_PER_WORD-1:0]   r_pack_erase;
    logic [SYM_PER_WORD-1:0]   w_slot_erase;
    logic [SYM_PER_WORD-1:0]   r_mem_erase [FIFO_DEPTH];
    logic                      w_erase_bit;
`else
    logic                      w_unused_dq;
    assign w_unused_dq = ^in_dq_min;
`endif

    // Symbol formation and malformed-candidate detection (even m or q_min[4])
    always_comb begin
        w_sym     = {in_q_min[3:0], gray_map(in_m_dI1), gray_map(in_m_dI2),
                     gray_map(in_m_dQ1), gray_map(in_m_dQ2)};
        w_sym_bad = in_q_min[4] | ~in_m_dI1[0] | ~in_m_dI2[0] |
                    ~in_m_dQ1[0] | ~in_m_dQ2[0];
    end

    // Word image including this cycle's symbol, if any
    always_comb begin
        w_slot_data = r_pack_data;
        for (int s = 0; s < SYM_PER_WORD; s++) begin
            if (in_valid && (r_pack_cnt == 3'(s))) begin
                w_slot_data[s*12 +: 12] = w_sym;
            end
        end
        w_cnt_after = r_pack_cnt + {2'b00, in_valid};
    end

`ifdef DQ_PACK_ERASURE_EN
    // Erasure flag image including this cycle's symbol
    always_comb begin
        w_erase_bit  = (in_dq_min > in_thresh);
        w_slot_erase = r_pack_erase;
        for (int s = 0; s < SYM_PER_WORD; s++) begin
            if (in_valid && (r_pack_cnt == 3'(s))) begin
                w_slot_erase[s] = w_erase_bit;
            end
        end
    end
`endif

    // Packer FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packer FSM next state: any push empties the packer
    always_comb begin
        w_state_nxt = r_state;
        if (w_push) begin
            w_state_nxt = S_IDLE;
        end else if (in_valid) begin
            w_state_nxt = S_FILL;
        end
    end

    // Packer FSM outputs: a completed word and a flush at the same edge push once
    always_comb begin
        w_word_done = (w_cnt_after == 3'(SYM_PER_WORD));
        w_push      = w_word_done | (flush & ((r_state == S_FILL) | in_valid));
    end

    // Partial word storage; cleared on push so unused slots read zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pack_cnt  <= 3'd0;
            r_pack_data <= '0;
        end else if (w_push) begin
            r_pack_cnt  <= 3'd0;
            r_pack_data <= '0;
        end else begin
            r_pack_cnt  <= w_cnt_after;
            r_pack_data <= w_slot_data;
        end
    end

`ifdef DQ_PACK_ERASURE_EN
    // Partial erasure flags, tracked alongside the partial word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pack_erase <= '0;
        end else if (w_push) begin
            r_pack_erase <= '0;
        end else begin
            r_pack_erase <= w_slot_erase;
        end
    end
`endif

    // FIFO control: a pop frees the slot for a same-cycle push even when full
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                  (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
        w_pop   = ~w_empty & out_ready;
        w_wr_en = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            if (w_pop)   r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage; reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_count[i] <= 3'd0;
            end
        end else if (w_wr_en) begin
            r_mem_data[r_wr_ptr[PW-1:0]]  <= w_slot_data;
            r_mem_count[r_wr_ptr[PW-1:0]] <= w_cnt_after;
        end
    end

`ifdef DQ_PACK_ERASURE_EN
    // FIFO erasure storage, written with its word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_erase[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem_erase[r_wr_ptr[PW-1:0]] <= w_slot_erase;
        end
    end

    assign out_erase = r_mem_erase[r_rd_ptr[PW-1:0]];
`endif

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && w_sym_bad) sym_err  <= 1'b1;
            if (w_drop)                overflow <= 1'b1;
        end
    end

    assign out_data  = r_mem_data[r_rd_ptr[PW-1:0]];
    assign out_count = r_mem_count[r_rd_ptr[PW-1:0]];
    assign out_valid = ~w_empty;
    assign busy      = (r_state == S_FILL) | ~w_empty;

endmodule
